// File: rtl/keccak_squeeze_buffer_if.sv
// Output word stream of the Keccak squeeze buffer: 64-bit data with a valid/ready handshake.
interface keccak_squeeze_buffer_if;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/keccak_squeeze_buffer.sv
// Squeeze stage after Keccak-f[1600]: captures the rate lanes of each permuted state and
// streams them as 64-bit words, requesting further permutations until num_words are delivered.
module keccak_squeeze_buffer #(
    parameter int RATE_LANES = 21,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_words,
    input  logic [1599:0]          state_in,
    input  logic                   state_valid,
    output logic                   perm_req,
    output logic                   busy,
    output logic                   done,
    keccak_squeeze_buffer_if.master out
);

    localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SQUEEZE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state_r;
    logic [63:0]        lane_buf_r [RATE_LANES];
    logic [IDX_W-1:0]   lane_idx_r;
    logic [CNT_W-1:0]   remaining_r;
    logic [63:0]        dout_r;
    logic               dout_valid_r;
    logic               perm_req_r;
    logic               busy_r;
    logic               done_r;

    logic               hs_s;
    logic               last_lane_s;
    logic               last_word_s;
    logic [IDX_W-1:0]   lane_nxt_s;

    // Capacity lanes are deliberately never stored; fold them away so they are visibly unused.
    generate
        if (RATE_LANES < 25) begin : g_cap
            logic unused_cap_s;
            assign unused_cap_s = ^state_in[1599:64*RATE_LANES];
        end
    endgenerate

    // Handshake and lane/word exhaustion decode from registered state only.
    always_comb begin
        hs_s        = 1'b0;
        last_lane_s = 1'b0;
        last_word_s = 1'b0;
        lane_nxt_s  = lane_idx_r + IDX_W'(1);
        if (state_r == ST_SQUEEZE) begin
            hs_s = dout_valid_r & out.dout_ready;
        end else begin
            hs_s = 1'b0;
        end
        last_lane_s = (lane_idx_r == IDX_W'(RATE_LANES - 1));
        last_word_s = (remaining_r == CNT_W'(1));
    end

    // Session FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            lane_idx_r   <= '0;
            remaining_r  <= '0;
            dout_r       <= 64'd0;
            dout_valid_r <= 1'b0;
            perm_req_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            for (int i = 0; i < RATE_LANES; i++) begin
                lane_buf_r[i] <= 64'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    perm_req_r   <= 1'b0;
                    done_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    if (start) begin
                        busy_r <= 1'b1;
                        if (num_words != '0) begin
                            remaining_r <= num_words;
                            perm_req_r  <= 1'b1;
                            state_r     <= ST_REQ;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    perm_req_r <= 1'b0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (state_valid) begin
                        for (int i = 0; i < RATE_LANES; i++) begin
                            lane_buf_r[i] <= state_in[64*i +: 64];
                        end
                        lane_idx_r   <= '0;
                        dout_r       <= state_in[63:0];
                        dout_valid_r <= 1'b1;
                        state_r      <= ST_SQUEEZE;
                    end
                end
                ST_SQUEEZE: begin
                    if (hs_s) begin
                        remaining_r <= remaining_r - CNT_W'(1);
                        // Finishing the session wins over a lane wrap on the same word.
                        if (last_word_s) begin
                            lane_idx_r   <= lane_nxt_s;
                            dout_valid_r <= 1'b0;
                            done_r       <= 1'b1;
                            state_r      <= ST_DONE;
                        end else if (last_lane_s) begin
                            lane_idx_r   <= '0;
                            dout_valid_r <= 1'b0;
                            perm_req_r   <= 1'b1;
                            state_r      <= ST_REQ;
                        end else begin
                            lane_idx_r <= lane_nxt_s;
                            dout_r     <= lane_buf_r[lane_nxt_s];
                        end
                    end
                end
                ST_DONE: begin
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    perm_req_r   <= 1'b0;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign out.dout       = dout_r;
    assign out.dout_valid = dout_valid_r;
    assign perm_req       = perm_req_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_keccak_squeeze_buffer.sv
// Randomized bench for keccak_squeeze_buffer: a word-stream model built from delivered states
// predicts every output each cycle; the bench also plays the permutation core.
module tb_keccak_squeeze_buffer;
    localparam int RATE = 21;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   num_words;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          perm_req;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [63:0] lanes_m [0:7][0:24];

    keccak_squeeze_buffer_if sq ();

    keccak_squeeze_buffer #(.RATE_LANES(RATE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .state_in(state_in), .state_valid(state_valid), .perm_req(perm_req),
        .busy(busy), .done(done), .out(sq.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Build permuted state k of the session; capacity lanes are random too.
    task automatic make_state(input int k, input bit directed);
        logic [63:0] lane;
        for (int i = 0; i < 25; i++) begin
            lane = {$urandom, $urandom};
            if (directed && k == 0) lane = 64'h1000 + 64'(i);
            if (directed && k == 1 && i == 0) lane = 64'hBEEF;
            lanes_m[k][i] = lane;
            state_in[64*i +: 64] = lane;
        end
    endtask

    task automatic session(input int n, input bit directed, input int stall_pct, input int stall_at);
        int words_out = 0;
        int delivered = 0;
        int perms = 0;
        int pending = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit stall_used = 1'b0;
        bit hs = 1'b0;
        bit sv_drv = 1'b0;
        bit waiting = 1'b0;
        bit fin = 1'b0;
        bit exp_perm;
        bit exp_done;
        bit exp_valid;
        @(negedge clk);
        start = 1'b1;
        num_words = 16'(n);
        @(negedge clk);
        start = 1'b0;
        num_words = 16'($urandom);
        exp_perm = (n > 0);
        exp_done = (n == 0);
        while (!fin && cyc < 3000) begin
            check("perm_req", perm_req, exp_perm);
            check("done", done, exp_done);
            check("busy", busy, 1'b1);
            exp_valid = (delivered * RATE > words_out) && (words_out < n);
            check("dout_valid", sq.dout_valid, exp_valid);
            if (exp_valid) check("dout", sq.dout, lanes_m[words_out / RATE][words_out % RATE]);
            start = 1'b0;
            state_valid = 1'b0;
            if (done) fin = 1'b1;
            if (perm_req) begin
                perms++;
                waiting = 1'b1;
                pending = $urandom_range(1, 3);
            end else if (waiting) begin
                pending--;
                if (pending == 0) begin
                    make_state(delivered, directed);
                    state_valid = 1'b1;
                    sv_drv = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                state_in = {50{$urandom}};
                state_valid = 1'b1;
            end
            if (!fin && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                num_words = 16'($urandom_range(0, 5));
            end
            if (!stall_used && stall_at >= 0 && words_out == stall_at) begin
                stall_used = 1'b1;
                stall_cnt = 5;
            end
            if (stall_cnt > 0) begin
                sq.dout_ready = 1'b0;
                stall_cnt--;
            end else begin
                sq.dout_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            hs = sq.dout_valid && sq.dout_ready;
            @(negedge clk);
            cyc++;
            exp_perm = 1'b0;
            exp_done = 1'b0;
            if (sv_drv) begin
                delivered++;
                sv_drv = 1'b0;
                waiting = 1'b0;
            end
            if (hs) begin
                words_out++;
                if (words_out == n) exp_done = 1'b1;
                else if (words_out % RATE == 0) exp_perm = 1'b1;
            end
        end
        start = 1'b0;
        state_valid = 1'b0;
        check("session_finished", fin, 1'b1);
        check("words_delivered", 64'(words_out), 64'(n));
        check("perm_count", 64'(perms), 64'((n + RATE - 1) / RATE));
        check("busy_after", busy, 1'b0);
        check("done_after", done, 1'b0);
        check("valid_after", sq.dout_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        num_words = 16'd0;
        state_in = '0;
        state_valid = 1'b0;
        sq.dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_perm_req", perm_req, 1'b0);
        check("rst_dout_valid", sq.dout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout", sq.dout, 64'd0);
        rst = 1'b1;

        session(3, 1'b1, 0, -1);
        session(21, 1'b0, 0, -1);
        session(22, 1'b1, 0, -1);
        session(5, 1'b0, 0, 2);

        // state_valid while idle must not start anything
        @(negedge clk);
        make_state(0, 1'b0);
        state_valid = 1'b1;
        @(negedge clk);
        state_valid = 1'b0;
        check("idle_sv_valid", sq.dout_valid, 1'b0);
        check("idle_sv_busy", busy, 1'b0);
        @(negedge clk);
        check("idle_sv_perm", perm_req, 1'b0);
        session(0, 1'b0, 0, -1);

        for (int s = 0; s < 6; s++) begin
            session($urandom_range(1, 70), 1'b0, 30, -1);
        end

        // asynchronous reset in the middle of a squeeze
        @(negedge clk);
        start = 1'b1;
        num_words = 16'd40;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !perm_req; i++) @(negedge clk);
        check("t6_perm", perm_req, 1'b1);
        @(negedge clk);
        make_state(0, 1'b0);
        state_valid = 1'b1;
        sq.dout_ready = 1'b1;
        @(negedge clk);
        state_valid = 1'b0;
        check("t6_valid", sq.dout_valid, 1'b1);
        @(negedge clk);
        check("t6_word1", sq.dout, lanes_m[0][1]);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", sq.dout_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_perm", perm_req, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_dout", sq.dout, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_done", done, 1'b0);
            check("t6_idle", busy, 1'b0);
        end
        session(2, 1'b1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keccak_squeeze_buffer.md
Name: keccak_squeeze_buffer

Overview:
- Squeeze-side stage directly downstream of the Keccak-f[1600] permutation core used by the Pasta XOF (SHAKE128).
- Captures the rate lanes of each permuted 1600-bit state and streams them out as 64-bit words over a valid/ready handshake.
- Requests a further permutation when the buffered rate is exhausted, until a requested word count has been delivered.

Parameters:
RATE_LANES, 21, number of 64-bit rate lanes per state (21 = SHAKE128, 1344 bits); legal range 1..25
CNT_W, 16, width of the word-count input and internal remaining-word counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
start  input  1  one-cycle pulse; begins a squeeze session; honoured only in IDLE
num_words  input  CNT_W  total 64-bit words to emit; sampled when start is honoured
state_in  input  1600  permuted state; lane i = x+5y at bits [64*i+63:64*i]
state_valid  input  1  one-cycle pulse; state_in holds the completed permutation result
perm_req  output  1  one-cycle pulse requesting the next permutation of the held state
dout  output  64  current output word
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both 1
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; session complete

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - perm_req, dout_valid, done and busy = 0; dout = 0.
  - Lane buffer, lane index and remaining counter cleared.
- FSM states: IDLE, REQ, WAIT, SQUEEZE, DONE.
- IDLE:
  - start=1 with num_words>0: latch remaining=num_words, go to REQ.
  - start=1 with num_words=0: go to DONE.
  - state_valid is ignored.
- REQ: perm_req=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold until state_valid=1.
  - On state_valid, register lanes 0..RATE_LANES-1 of state_in into the lane buffer, set lane_idx=0, go to SQUEEZE.
  - Capacity lanes are never stored.
- SQUEEZE:
  - dout_valid=1; dout = buffer lane lane_idx, driven from registers only.
  - No combinational path from dout_ready to any output.
  - On handshake, decrement remaining and increment lane_idx. Then:
    - remaining reaches 0: go to DONE (takes priority).
    - Otherwise, handshake on lane_idx=RATE_LANES-1: go to REQ and wrap lane_idx to 0.
    - Otherwise: stay in SQUEEZE.
  - While dout_ready=0, dout and dout_valid are held stable.
- DONE: done=1 for exactly this cycle, dout_valid=0, then go to IDLE.
- Latencies:
  - start → perm_req: 1 cycle.
  - state_valid → first dout_valid: 1 cycle.
  - Last handshake → done: 1 cycle.
  - Lane-exhaustion handshake → perm_req: 1 cycle.
- Peak throughput: one word per cycle within a state.
- Ignored inputs:
  - start outside IDLE.
  - state_valid outside WAIT.
- Remaining counter never underflows: the DONE transition precedes any further decrement.
- The lane buffer is overwritten only on a captured state_valid; its contents persist through REQ and WAIT.
- Reset mid-session abandons the session. No done pulse is produced; the next session requires a new start.

Test Plan:
1. rst=0 pulse; start, num_words=3; state_valid with lane i=64'h1000+i → one perm_req; dout 64'h1000, 64'h1001, 64'h1002 on consecutive cycles (dout_ready=1); done 1 cycle after third handshake; busy low after.
2. num_words=21, dout_ready=1 → exactly one perm_req; 21 words (lanes 0..20); no second perm_req; done follows.
3. num_words=22 → perm_req again 1 cycle after lane-20 handshake. Second state has lane 0=64'hBEEF → word 22 = 64'hBEEF. Capacity lanes 21..24 never appear on dout.
4. num_words=5, dout_ready low for 5 cycles after the second word → dout and dout_valid stable throughout; the count resumes correctly and done fires after word 5.
5. start with num_words=0 → done pulse next cycle, no perm_req, no dout_valid. A state_valid pulse in IDLE, and a start pulse in SQUEEZE, have no effect.
6. rst=0 asserted asynchronously mid-SQUEEZE → dout_valid, busy and perm_req drop to 0 immediately, with no done pulse. A fresh start with num_words=2 then behaves as in test 1.
